// File: rtl/led_pattern_ctrl.sv
// Four-LED pattern sequencer: prescaled step tick, four display modes, pause and speed control.
// Optional macro LED_PWM_DIM_EN adds dim_duty and a 4-bit PWM mask on the led outputs.
module led_pattern_ctrl #(
    parameter int TICK_BASE = 10_000_000,
    parameter int CNT_W     = 24
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       mode_next,
    input  logic [1:0] speed_sel,
    input  logic       pause,
`ifdef LED_PWM_DIM_EN
    input  logic [3:0] dim_duty,
`endif
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       step_tick
);

    typedef enum logic [1:0] {
        FLOW_L   = 2'd0,
        FLOW_R   = 2'd1,
        BLINK    = 2'd2,
        PINGPONG = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    mode_t            mode_q, mode_d;
    dir_t             dir_q, dir_d;
    logic [3:0]       pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] last_cnt;
    logic             terminal;

    // >= rather than == so that shortening the period never strands cnt past the wrap
    assign period   = CNT_W'(TICK_BASE >> speed_sel);
    assign last_cnt = period - CNT_W'(1);
    assign terminal = (cnt_q >= last_cnt);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q <= FLOW_L;
            dir_q  <= DIR_UP;
            pat_q  <= 4'b0001;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            pat_q  <= pat_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        pat_d  = pat_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (mode_next) begin
            // a mode change discards any step that lands on the same edge
            mode_d = mode_t'(mode_q + 2'd1);
            dir_d  = DIR_UP;
            cnt_d  = '0;
            case (mode_d)
                FLOW_L:   pat_d = 4'b0001;
                FLOW_R:   pat_d = 4'b1000;
                BLINK:    pat_d = 4'b1111;
                PINGPONG: pat_d = 4'b0001;
                default:  pat_d = 4'b0001;
            endcase
        end else if (!pause && terminal) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            case (mode_q)
                FLOW_L: pat_d = {pat_q[2:0], pat_q[3]};
                FLOW_R: pat_d = {pat_q[0], pat_q[3:1]};
                BLINK:  pat_d = ~pat_q;
                PINGPONG: begin
                    if (dir_q == DIR_UP) begin
                        pat_d = {pat_q[2:0], 1'b0};
                        if (pat_q[2]) dir_d = DIR_DOWN;
                    end else begin
                        pat_d = {1'b0, pat_q[3:1]};
                        if (pat_q[1]) dir_d = DIR_UP;
                    end
                end
                default: pat_d = pat_q;
            endcase
        end else if (!pause) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign mode      = mode_q;
    assign step_tick = tick_q;

`ifdef LED_PWM_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) pwm_cnt <= 4'd0;
        else         pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign led = pat_q & {4{pwm_cnt < dim_duty}};
`else
    assign led = pat_q;
`endif

endmodule
